// File: rtl/pid_pkg.sv
// rtl/pid_pkg.sv - shared widths, default gains and the signed clamp helper for the PID core
package pid_pkg;

  localparam int ERR_W   = 10;
  localparam int INTEG_W = 16;
  localparam int DDIFF_W = 7;
  localparam int OUT_W   = 12;
  localparam int PTERM_W = 14;
  localparam int ITERM_W = 12;
  localparam int DTERM_W = 12;
  localparam int SUM_W   = 15;

  localparam logic signed [3:0] P_COEFF_DEF = 4'sd3;
  localparam logic signed [4:0] D_COEFF_DEF = 5'sd7;

  // Clamp v into the signed range of a w-bit two's complement number.
  function automatic int sat_signed(input int v, input int w);
    int hi;
    int lo;
    hi = (1 <<< (w - 1)) - 1;
    lo = -(1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/pid_dqueue.sv
// rtl/pid_dqueue.sv - shift-on-enable history of past error samples for the derivative term
module pid_dqueue
  import pid_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = ERR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                shift_en,
  input  logic signed [W-1:0] din,
  output logic signed [W-1:0] oldest
);

  logic signed [W-1:0] q_q [DEPTH];
  logic signed [W-1:0] q_d [DEPTH];

  // Entry 0 is the newest sample; a shift pushes din in and drops the last entry.
  always_comb begin
    q_d = q_q;
    if (shift_en) begin
      q_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        q_d[i] = q_q[i-1];
      end
    end
  end

  // History registers, cleared to zero so the first sample sees an all-zero past.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_q[i] <= '0;
      end
    end else begin
      q_q <= q_d;
    end
  end

  assign oldest = q_q[DEPTH-1];

endmodule

// File: rtl/pid_core.sv
// rtl/pid_core.sv - three-stage fixed-point PID controller with saturating integrator and derivative
module pid_core
  import pid_pkg::*;
#(
  parameter logic signed [3:0] P_COEFF       = P_COEFF_DEF,
  parameter logic signed [4:0] D_COEFF       = D_COEFF_DEF,
  parameter int                D_QUEUE_DEPTH = 2            // legal 1..4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    err_vld,
  input  logic signed [ERR_W-1:0] err_sat,
  input  logic                    clr_integ,
  output logic                    pid_vld,
  output logic signed [OUT_W-1:0] pid_out
);

  logic signed [ERR_W-1:0]   d_oldest;

  logic signed [INTEG_W-1:0] integ_q, integ_d;
  logic signed [INTEG_W-1:0] err_ext, integ_sum;
  logic                      integ_ovf;

  logic                      s1_vld_q, s1_vld_d;
  logic signed [PTERM_W-1:0] p_term_q, p_term_d;
  logic signed [DDIFF_W-1:0] d_diff_q, d_diff_d;

  logic                      s2_vld_q, s2_vld_d;
  logic signed [PTERM_W-1:0] p2_q, p2_d;
  logic signed [ITERM_W-1:0] i_term_q, i_term_d;
  logic signed [DTERM_W-1:0] d_term_q, d_term_d;

  logic signed [SUM_W-1:0]   sum_w;
  logic                      pid_vld_q, pid_vld_d;
  logic signed [OUT_W-1:0]   pid_out_q, pid_out_d;

  pid_dqueue #(
    .DEPTH (D_QUEUE_DEPTH),
    .W     (ERR_W)
  ) u_dqueue (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (err_vld),
    .din      (err_sat),
    .oldest   (d_oldest)
  );

  // Integrator: clear has priority; an overflowing add leaves the old value in place.
  always_comb begin
    err_ext   = INTEG_W'(err_sat);
    integ_sum = integ_q + err_ext;
    integ_ovf = (integ_q[INTEG_W-1] == err_ext[INTEG_W-1]) &&
                (integ_sum[INTEG_W-1] != integ_q[INTEG_W-1]);
    integ_d   = integ_q;
    if (clr_integ) begin
      integ_d = '0;
    end else if (err_vld && !integ_ovf) begin
      integ_d = integ_sum;
    end
  end

  // Stage 1: proportional product and clamped first difference against the oldest sample.
  always_comb begin
    s1_vld_d = err_vld;
    p_term_d = p_term_q;
    d_diff_d = d_diff_q;
    if (err_vld) begin
      p_term_d = PTERM_W'(err_sat) * PTERM_W'(P_COEFF);
      d_diff_d = DDIFF_W'(sat_signed(int'(err_sat) - int'(d_oldest), DDIFF_W));
    end
  end

  // Stage 2: scale the difference, and snapshot the integrator so later clears or adds
  // cannot disturb a sample already in flight.
  always_comb begin
    s2_vld_d = s1_vld_q;
    p2_d     = p2_q;
    i_term_d = i_term_q;
    d_term_d = d_term_q;
    if (s1_vld_q) begin
      p2_d     = p_term_q;
      i_term_d = integ_q[INTEG_W-1 -: ITERM_W];
      d_term_d = DTERM_W'(sat_signed(int'(d_diff_q) * int'(D_COEFF), DTERM_W));
    end
  end

  // Output stage: wide sum of the three terms clamped to the output range, held between strobes.
  always_comb begin
    sum_w     = SUM_W'(p2_q) + SUM_W'(i_term_q) + SUM_W'(d_term_q);
    pid_vld_d = s2_vld_q;
    pid_out_d = pid_out_q;
    if (s2_vld_q) begin
      pid_out_d = OUT_W'(sat_signed(int'(sum_w), OUT_W));
    end
  end

  // All state; reset drops every in-flight valid so no strobe follows a mid-stream reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integ_q   <= '0;
      s1_vld_q  <= 1'b0;
      p_term_q  <= '0;
      d_diff_q  <= '0;
      s2_vld_q  <= 1'b0;
      p2_q      <= '0;
      i_term_q  <= '0;
      d_term_q  <= '0;
      pid_vld_q <= 1'b0;
      pid_out_q <= '0;
    end else begin
      integ_q   <= integ_d;
      s1_vld_q  <= s1_vld_d;
      p_term_q  <= p_term_d;
      d_diff_q  <= d_diff_d;
      s2_vld_q  <= s2_vld_d;
      p2_q      <= p2_d;
      i_term_q  <= i_term_d;
      d_term_q  <= d_term_d;
      pid_vld_q <= pid_vld_d;
      pid_out_q <= pid_out_d;
    end
  end

  assign pid_vld = pid_vld_q;
  assign pid_out = pid_out_q;

endmodule

// File: tb/tb_pid_core.sv
// tb/tb_pid_core.sv - self-checking bench for pid_core: directed table, corner sequences, random vs model
module tb_pid_core;

  localparam int DEPTH = 2;

  logic              clk;
  logic              rst_n;
  logic              err_vld;
  logic signed [9:0] err_sat;
  logic              clr_integ;
  logic              pid_vld;
  logic signed [11:0] pid_out;

  pid_core #(
    .P_COEFF       (4'sd3),
    .D_COEFF       (5'sd7),
    .D_QUEUE_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .err_vld   (err_vld),
    .err_sat   (err_sat),
    .clr_integ (clr_integ),
    .pid_vld   (pid_vld),
    .pid_out   (pid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int ecnt   = 0;

  // reference model state
  int m_integ;
  int m_dq[$];
  int exp_q[$];
  int due_q[$];
  int last_out;

  typedef struct {
    logic rst;
    logic v;
    int   e;
    logic c;
    logic ev;
    int   eo;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_reset();
    m_integ = 0;
    m_dq.delete();
    for (int i = 0; i < DEPTH; i++) m_dq.push_back(0);
    exp_q.delete();
    due_q.delete();
    last_out = 0;
  endtask

  task automatic model_edge(input logic v, input int e, input logic c);
    int s, oldest, diff, p, i, d;
    if (c) begin
      m_integ = 0;
    end else if (v) begin
      s = m_integ + e;
      if (s <= 32767 && s >= -32768) m_integ = s;
    end
    if (v) begin
      oldest = m_dq[0];
      diff   = clamp(e - oldest, -64, 63);
      d      = clamp(diff * 7, -2048, 2047);
      p      = e * 3;
      i      = m_integ >>> 4;
      exp_q.push_back(clamp(p + i + d, -2048, 2047));
      due_q.push_back(ecnt + 2);
      void'(m_dq.pop_front());
      m_dq.push_back(e);
    end
  endtask

  task automatic check_outputs();
    logic ev;
    ev = (due_q.size() > 0) && (due_q[0] == ecnt);
    chk("model_vld", int'(pid_vld), int'(ev));
    if (ev) begin
      last_out = exp_q.pop_front();
      void'(due_q.pop_front());
    end
    chk("model_out", int'(pid_out), last_out);
  endtask

  // one clock: drive, take the edge, update model, sample 1ns later
  task automatic step(input logic v, input int e, input logic c);
    err_vld   = v;
    err_sat   = 10'(e);
    clr_integ = c;
    @(posedge clk);
    ecnt++;
    model_edge(v, e, c);
    #1;
    check_outputs();
    err_vld   = 1'b0;
    clr_integ = 1'b0;
  endtask

  task automatic do_reset();
    err_vld   = 1'b0;
    clr_integ = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // reset asserted between edges with samples in flight; outputs must drop at once
  task automatic async_reset_check();
    #2;
    rst_n     = 1'b0;
    err_vld   = 1'b0;
    clr_integ = 1'b0;
    #1;
    chk("async_rst_vld", int'(pid_vld), 0);
    chk("async_rst_out", int'(pid_out), 0);
    chk("async_rst_integ", int'(dut.integ_q), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int e;
    logic v, c;

    rst_n     = 1'b0;
    err_vld   = 1'b0;
    err_sat   = '0;
    clr_integ = 1'b0;
    model_reset();
    #1;
    chk("reset_vld", int'(pid_vld), 0);
    chk("reset_out", int'(pid_out), 0);
    chk("reset_integ", int'(dut.integ_q), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // directed table: first sample after reset, back-to-back 511 with D saturating then zero
    tbl.push_back('{1'b1, 1'b1, 16,  1'b0, 1'b0, 0});
    tbl.push_back('{1'b0, 1'b0, 0,   1'b0, 1'b0, 0});
    tbl.push_back('{1'b0, 1'b0, 0,   1'b0, 1'b1, 161});
    tbl.push_back('{1'b0, 1'b0, 0,   1'b0, 1'b0, 161});
    tbl.push_back('{1'b1, 1'b1, 511, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b0, 1'b1, 511, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b0, 1'b1, 511, 1'b0, 1'b1, 2005});
    tbl.push_back('{1'b0, 1'b0, 0,   1'b0, 1'b1, 2037});
    tbl.push_back('{1'b0, 1'b0, 0,   1'b0, 1'b1, 1628});
    tbl.push_back('{1'b0, 1'b0, 0,   1'b0, 1'b0, 1628});
    for (int k = 0; k < tbl.size(); k++) begin
      if (tbl[k].rst) do_reset();
      step(tbl[k].v, tbl[k].e, tbl[k].c);
      chk("tbl_vld", int'(pid_vld), int'(tbl[k].ev));
      chk("tbl_out", int'(pid_out), tbl[k].eo);
    end

    // most negative input, then clear racing a new sample: clear wins
    do_reset();
    step(1'b1, -512, 1'b0);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    chk("neg_vld", int'(pid_vld), 1);
    chk("neg_out", int'(pid_out), -2016);
    step(1'b1, 5, 1'b1);
    chk("clr_wins_integ", int'(dut.integ_q), 0);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    chk("clr_sample_out", int'(pid_out), 50);

    // integrator overflow: the 65th 511 would wrap, so the register holds
    do_reset();
    for (int k = 1; k <= 65; k++) begin
      step(1'b1, 511, 1'b0);
      if (k == 64 || k == 65) chk("integ_hold", int'(dut.integ_q), 32704);
    end
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    chk("sat_out", int'(pid_out), 2047);

    // random traffic against the model, with a positively biased stretch and a mid-stream reset
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i == 300) async_reset_check();
      v = ($urandom_range(0, 9) < 7);
      c = ($urandom_range(0, 19) == 0);
      if (i >= 100 && i < 250)
        e = ($urandom_range(0, 9) == 0) ? -512 : 511;
      else
        e = int'($urandom_range(0, 1023)) - 512;
      step(v, e, c);
    end
    repeat (3) step(1'b0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pid_core.md
PID_CORE -- requirements
Module: pid_core

Interface
REQ-001 Parameter P_COEFF, 4'sd3, signed 4-bit proportional gain SHALL be provided.
REQ-002 Parameter D_COEFF, 5'sd7, signed 5-bit derivative gain SHALL be provided.
REQ-003 Parameter D_QUEUE_DEPTH, 2, number of past error samples held for the derivative SHALL be provided; legal range 1-4.
REQ-004 Clocking and reset SHALL be fixed: one clock; reset is asynchronous and active-low.
REQ-005 Port clk  in  1  SHALL be the sole clock, rising edge.
REQ-006 Port rst_n  in  1  SHALL be the asynchronous active-low reset.
REQ-007 Port err_vld  in  1  SHALL be a one-cycle strobe marking a new err_sat sample.
REQ-008 Port err_sat  in  10  SHALL be a signed error sample already saturated to -512..511.
REQ-009 Port clr_integ  in  1  SHALL be a synchronous integrator clear request.
REQ-010 Port pid_vld  out  1  SHALL be a one-cycle strobe marking a new pid_out.
REQ-011 Port pid_out  out  12  SHALL be the signed control output, -2048..2047.

Function
REQ-012 Stage 1 on an err_vld edge SHALL register P_term = err_sat*P_COEFF as 14-bit signed.
REQ-013 Integrator SHALL be a 16-bit signed register; on err_vld it SHALL add sign-extended err_sat.
REQ-014 If the integrator sum overflows (operands same sign, result sign differs), it SHALL hold its previous value.
REQ-015 clr_integ SHALL zero the integrator at the next edge; with simultaneous err_vld, clear SHALL win (result 0, sample not added).
REQ-016 I_term SHALL be integrator[15:4], 12-bit signed.
REQ-017 D_diff SHALL be err_sat minus the oldest queued sample, 11-bit signed, saturated to 7-bit signed -64..63.
REQ-018 D_term SHALL be saturated D_diff*D_COEFF, 12-bit signed.
REQ-019 On each err_vld the queue SHALL shift in err_sat and drop the oldest entry; without err_vld the queue SHALL hold.
REQ-020 Stage 2 SHALL sum sign-extended P_term, I_term and D_term in 15 bits and saturate the sum to 12-bit signed into pid_out.
REQ-021 Latency SHALL be fixed: err_vld sampled at edge n yields pid_vld high for exactly the cycle following edge n+2.
REQ-022 err_vld on every consecutive cycle SHALL be supported with one pid_vld per input and no drops.
REQ-023 pid_out SHALL hold its last value between pid_vld pulses.
REQ-024 clr_integ SHALL NOT affect the derivative queue or the in-flight pipeline.

Reset
REQ-025 rst_n low SHALL asynchronously zero the integrator, all queue entries, all pipeline registers, pid_out and pid_vld.
REQ-026 Reset mid-operation SHALL discard in-flight samples; no pid_vld SHALL follow for them.
REQ-027 The first sample after reset SHALL see queued values of 0, so D_diff = err_sat.

Structure
REQ-028 Widths (ERR_W=10, INTEG_W=16, DDIFF_W=7, OUT_W=12) and the default gains SHALL live in shared package pid_pkg.
REQ-029 The derivative history SHALL be a sub-module pid_dqueue (parameterised depth, enable-shift, async clear).
REQ-030 The signed clamp SHALL be a single function reused for D_diff and the output sum.

Verification
REQ-031 Reset asserted mid-stream -> pid_out=0, pid_vld=0 immediately; the queue reads 0.
REQ-032 After reset, one err_vld with err_sat=16 -> pid_vld two cycles later with pid_out=161 (P 48, I 1, D 112).
REQ-033 err_sat=511 for three back-to-back strobes -> pid_out=2005, 2037, 1628 on consecutive cycles (D saturated to 63, then 0).
REQ-034 err_sat=511 for 65 strobes -> integrator holds at 32704 (0x7FC0) on the 65th, pid_out=2047 (saturated).
REQ-035 After reset, err_sat=-512 -> pid_out=-2016 (12'h820); then clr_integ with err_vld -> integrator reads 0.
